// File: rtl/program_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | program_loader_if : UART byte stream in, program-memory write out     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface program_loader_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        mem_write_enable;
   logic [31:0] mem_byte_address;
   logic [31:0] mem_write_data;
   logic        loader_active;
   logic        cpu_run;
   logic        load_error;

   // The loader is master of the memory write port and consumes rx bytes.
   modport master (
      input  rx_valid,
      input  rx_data,
      output mem_write_enable,
      output mem_byte_address,
      output mem_write_data,
      output loader_active,
      output cpu_run,
      output load_error
   );

   modport slave (
      output rx_valid,
      output rx_data,
      input  mem_write_enable,
      input  mem_byte_address,
      input  mem_write_data,
      input  loader_active,
      input  cpu_run,
      input  load_error
   );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | program_loader : frames a UART program image, writes it to memory,    |
// | releases the core after a checksum-valid load.        Rev 1.0         |
// +----------------------------------------------------------------------+
module program_loader #(
   parameter int unsigned MAX_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  wire logic         clk,
   input  wire logic         reset,
   program_loader_if.master  bus
);

   localparam logic [7:0]  c_MAGIC     = 8'hA5;
   localparam logic [31:0] c_MAX_WORDS = 32'(MAX_WORDS);

   typedef enum logic [2:0] {
      WAIT_MAGIC = 3'd0,
      LEN_LO     = 3'd1,
      LEN_HI     = 3'd2,
      PAYLOAD    = 3'd3,
      CHECK      = 3'd4,
      RUN        = 3'd5,
      ERROR      = 3'd6
   } state_t;

   state_t      state_q;
   logic [1:0]  byte_cnt_q;
   logic [15:0] word_cnt_q;
   logic [15:0] len_q;
   logic [7:0]  chk_q;
   logic [23:0] asm_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_data_q;
   logic        active_q;
   logic        run_q;
   logic        err_q;

   logic [15:0] len_d;
   logic [7:0]  chk_d;
   logic        last_word_d;

   assign len_d       = {bus.rx_data, len_q[7:0]};
   assign chk_d       = chk_q ^ bus.rx_data;
   assign last_word_d = ((word_cnt_q + 16'd1) == len_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= WAIT_MAGIC;
         byte_cnt_q <= 2'd0;
         word_cnt_q <= 16'd0;
         len_q      <= 16'd0;
         chk_q      <= 8'd0;
         asm_q      <= 24'd0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= BASE_ADDR;
         mem_data_q <= 32'd0;
         active_q   <= 1'b1;
         run_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         if (bus.rx_valid) begin
            case (state_q)
               WAIT_MAGIC, RUN, ERROR: begin
                  // A magic byte restarts a load from any idle state and
                  // immediately takes the core back into reset.
                  if (bus.rx_data == c_MAGIC) begin
                     state_q    <= LEN_LO;
                     chk_q      <= 8'd0;
                     byte_cnt_q <= 2'd0;
                     word_cnt_q <= 16'd0;
                     err_q      <= 1'b0;
                     run_q      <= 1'b0;
                     active_q   <= 1'b1;
                  end
               end
               LEN_LO: begin
                  len_q   <= {8'd0, bus.rx_data};
                  chk_q   <= chk_d;
                  state_q <= LEN_HI;
               end
               LEN_HI: begin
                  len_q <= len_d;
                  chk_q <= chk_d;
                  if ({16'd0, len_d} > c_MAX_WORDS) begin
                     state_q <= ERROR;
                     err_q   <= 1'b1;
                  end else if (len_d == 16'd0) begin
                     state_q <= CHECK;
                  end else begin
                     state_q <= PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  chk_q <= chk_d;
                  if (byte_cnt_q == 2'd3) begin
                     mem_we_q   <= 1'b1;
                     mem_addr_q <= BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
                     mem_data_q <= {bus.rx_data, asm_q};
                     word_cnt_q <= word_cnt_q + 16'd1;
                     byte_cnt_q <= 2'd0;
                     if (last_word_d) begin
                        state_q <= CHECK;
                     end
                  end else begin
                     // Shift right so byte k ends up in bits [8k+7:8k].
                     asm_q      <= {bus.rx_data, asm_q[23:8]};
                     byte_cnt_q <= byte_cnt_q + 2'd1;
                  end
               end
               CHECK: begin
                  if (bus.rx_data == chk_q) begin
                     state_q  <= RUN;
                     run_q    <= 1'b1;
                     active_q <= 1'b0;
                  end else begin
                     state_q <= ERROR;
                     err_q   <= 1'b1;
                  end
               end
               default: begin
                  state_q <= WAIT_MAGIC;
               end
            endcase
         end
      end
   end

   assign bus.mem_write_enable = mem_we_q;
   assign bus.mem_byte_address = mem_addr_q;
   assign bus.mem_write_data   = mem_data_q;
   assign bus.loader_active    = active_q;
   assign bus.cpu_run          = run_q;
   assign bus.load_error       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_program_loader : directed scoreboard bench for program_loader      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_program_loader;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   logic [63:0] exp_q [$];

   program_loader_if ifc ();

   program_loader #(
      .MAX_WORDS (1024),
      .BASE_ADDR (32'h0000_0000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Write monitor: every strobe must match the next expected (addr,data).
   always @(negedge clk) begin
      if (ifc.mem_write_enable === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write_addr", ifc.mem_byte_address, 32'hFFFF_FFFF);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("write_addr", ifc.mem_byte_address, e[63:32]);
            check("write_data", ifc.mem_write_data, e[31:0]);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at posedge+1; the byte is accepted on the next rising edge.
   task automatic send(input logic [7:0] b, input int gap);
      ifc.rx_valid = 1'b1;
      ifc.rx_data  = b;
      @(posedge clk);
      #1;
      ifc.rx_valid = 1'b0;
      ifc.rx_data  = 8'h00;
      idle(gap);
   endtask

   // Sends magic, length and payload; returns the correct checksum.
   task automatic send_frame(input logic [31:0] w [4], input int n, input int gap,
                             output logic [7:0] chk);
      logic [7:0] b;
      chk = 8'h00;
      send(8'hA5, gap);
      b = n[7:0];   chk ^= b; send(b, gap);
      b = n[15:8];  chk ^= b; send(b, gap);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 4; k++) begin
            b = w[i][8*k +: 8];
            chk ^= b;
            if (k == 3) exp_q.push_back({32'(4 * i), w[i]});
            send(b, gap);
         end
      end
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      idle(cycles);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] w [4];
      logic [7:0]  chk;
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1;
      ifc.rx_valid = 1'b0;
      ifc.rx_data  = 8'h00;
      @(posedge clk);
      #1;
      do_reset(3);

      check("rst_cpu_run", 32'(ifc.cpu_run), 32'd0);
      check("rst_active", 32'(ifc.loader_active), 32'd1);
      check("rst_error", 32'(ifc.load_error), 32'd0);
      check("rst_we", 32'(ifc.mem_write_enable), 32'd0);
      check("rst_addr", ifc.mem_byte_address, 32'h0);
      check("rst_data", ifc.mem_write_data, 32'h0);

      // Two-word load, one byte per 16 cycles.
      w = '{32'h0050_0093, 32'h0010_0113, 32'h0, 32'h0};
      send_frame(w, 2, 15, chk);
      check("two_word_chk_model", 32'(chk), 32'hC3);
      check("pre_chk_run", 32'(ifc.cpu_run), 32'd0);
      check("pre_chk_active", 32'(ifc.loader_active), 32'd1);
      send(8'hC3, 0);
      check("load_run", 32'(ifc.cpu_run), 32'd1);
      check("load_active", 32'(ifc.loader_active), 32'd0);
      check("load_error", 32'(ifc.load_error), 32'd0);
      idle(4);
      check("two_word_writes_done", 32'(exp_q.size()), 32'd0);

      // Reload during RUN.
      send(8'hA5, 0);
      check("reload_run_drop", 32'(ifc.cpu_run), 32'd0);
      check("reload_active", 32'(ifc.loader_active), 32'd1);
      send(8'h01, 2); send(8'h00, 2);
      exp_q.push_back({32'h0, 32'hDEAD_BEEF});
      send(8'hEF, 2); send(8'hBE, 2); send(8'hAD, 2); send(8'hDE, 2);
      check("reload_pre_chk_run", 32'(ifc.cpu_run), 32'd0);
      send(8'h23, 0);
      check("reload_run", 32'(ifc.cpu_run), 32'd1);
      idle(3);

      // Bad checksum, then a correct resend.
      w = '{32'h0050_0093, 32'h0010_0113, 32'h0, 32'h0};
      send_frame(w, 2, 1, chk);
      send(8'hC4, 0);
      check("bad_chk_error", 32'(ifc.load_error), 32'd1);
      check("bad_chk_run", 32'(ifc.cpu_run), 32'd0);
      check("bad_chk_active", 32'(ifc.loader_active), 32'd1);
      idle(5);
      check("bad_chk_error_hold", 32'(ifc.load_error), 32'd1);
      send(8'hA5, 0);
      check("magic_clears_error", 32'(ifc.load_error), 32'd0);
      send(8'h02, 0); send(8'h00, 0);
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 4; k++) begin
            if (k == 3) exp_q.push_back({32'(4 * i), w[i]});
            send(w[i][8*k +: 8], 0);
         end
      end
      send(8'hC3, 0);
      check("resend_run", 32'(ifc.cpu_run), 32'd1);
      check("resend_error", 32'(ifc.load_error), 32'd0);
      idle(3);

      // Empty image with leading noise at full rate, from reset.
      do_reset(1);
      send(8'h00, 0); send(8'hFF, 0); send(8'h5A, 0);
      check("noise_ignored_active", 32'(ifc.loader_active), 32'd1);
      send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
      check("empty_pre_chk_run", 32'(ifc.cpu_run), 32'd0);
      send(8'h00, 0);
      check("empty_run", 32'(ifc.cpu_run), 32'd1);
      check("empty_error", 32'(ifc.load_error), 32'd0);
      idle(3);

      // Oversize length (1025 words).
      send(8'hA5, 0); send(8'h01, 0);
      check("oversize_pre_error", 32'(ifc.load_error), 32'd0);
      send(8'h04, 0);
      check("oversize_error", 32'(ifc.load_error), 32'd1);
      check("oversize_run", 32'(ifc.cpu_run), 32'd0);
      for (int i = 0; i < 8; i++) send(8'(i + 1), 0);
      check("oversize_error_hold", 32'(ifc.load_error), 32'd1);
      idle(3);

      // Reset after the second payload byte of a word.
      send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0);
      send(8'h11, 0); send(8'h22, 0);
      do_reset(1);
      check("midrst_run", 32'(ifc.cpu_run), 32'd0);
      check("midrst_active", 32'(ifc.loader_active), 32'd1);
      check("midrst_error", 32'(ifc.load_error), 32'd0);
      check("midrst_we", 32'(ifc.mem_write_enable), 32'd0);
      check("midrst_addr", ifc.mem_byte_address, 32'h0);
      check("midrst_data", ifc.mem_write_data, 32'h0);
      w = '{32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_C0DE, 32'h0};
      send_frame(w, 3, 0, chk);
      send(chk, 0);
      check("midrst_reload_run", 32'(ifc.cpu_run), 32'd1);
      idle(4);
      check("all_writes_seen", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
